// File: rtl/dti_stream_monitor.sv
// Passive DTI channel checker: flags valid drops and data changes on a pending transfer,
// records the first error, and keeps saturating handshake/stall/idle/cycle counters.
module dti_stream_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     data,
  input  logic             valid,
  input  logic             ready,
  input  logic             checks_enable,
  input  logic             clear,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] hs_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] idle_cnt,
  output logic             err_valid_drop,
  output logic             err_data_change,
  output logic [1:0]       err_first_code,
  output logic [CNT_W-1:0] err_first_cycle,
  output logic [W-1:0]     err_first_data
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // A clear restarts the count from this cycle's increment; otherwise hold at max.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc,
                                               input logic clr);
    logic [CNT_W-1:0] res;
    if (clr)
      res = inc ? CNT_ONE : CNT_ZERO;
    else if (inc && (cnt != CNT_MAX))
      res = cnt + CNT_ONE;
    else
      res = cnt;
    return res;
  endfunction

  logic         pending_p1;
  logic [W-1:0] prev_data_p1;

  logic hs_p0, stall_p0, idle_p0;
  logic vd_p0, dc_p0, first_load_p0;

  // Stage p0: classify the sampled cycle against the previous cycle's pending state
  always_comb begin
    hs_p0         = valid & ready;
    stall_p0      = valid & ~ready;
    idle_p0       = ~valid;
    vd_p0         = checks_enable & pending_p1 & ~valid;
    dc_p0         = checks_enable & pending_p1 & valid & (data != prev_data_p1);
    first_load_p0 = (vd_p0 | dc_p0) &
                    (clear | ~(err_valid_drop | err_data_change));
  end

  // Stage p1: tracking state, counters and sticky error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p1      <= 1'b0;
      prev_data_p1    <= '0;
      cycle_cnt       <= '0;
      hs_cnt          <= '0;
      stall_cnt       <= '0;
      idle_cnt        <= '0;
      err_valid_drop  <= 1'b0;
      err_data_change <= 1'b0;
      err_first_code  <= 2'b00;
      err_first_cycle <= '0;
      err_first_data  <= '0;
    end else begin
      pending_p1      <= stall_p0;
      prev_data_p1    <= data;
      cycle_cnt       <= sat_inc(cycle_cnt, 1'b1, clear);
      hs_cnt          <= sat_inc(hs_cnt, hs_p0, clear);
      stall_cnt       <= sat_inc(stall_cnt, stall_p0, clear);
      idle_cnt        <= sat_inc(idle_cnt, idle_p0, clear);
      err_valid_drop  <= (err_valid_drop & ~clear) | vd_p0;
      err_data_change <= (err_data_change & ~clear) | dc_p0;
      if (first_load_p0) begin
        err_first_code  <= {dc_p0, vd_p0};
        err_first_cycle <= clear ? CNT_ZERO : cycle_cnt;
        err_first_data  <= data;
      end else if (clear) begin
        err_first_code  <= 2'b00;
        err_first_cycle <= '0;
        err_first_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dti_stream_monitor.sv
// Directed bench for dti_stream_monitor: a default-width instance plus a CNT_W=4
// instance on the same wires for counter saturation.
module tb_dti_stream_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        valid, ready, checks_enable, clear;

  logic [31:0] cycle_cnt, hs_cnt, stall_cnt, idle_cnt, err_first_cycle;
  logic        err_valid_drop, err_data_change;
  logic [1:0]  err_first_code;
  logic [15:0] err_first_data;

  logic [3:0]  s_cycle_cnt, s_hs_cnt, s_stall_cnt, s_idle_cnt, s_err_first_cycle;
  logic        s_err_valid_drop, s_err_data_change;
  logic [1:0]  s_err_first_code;
  logic [15:0] s_err_first_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dti_stream_monitor #(.W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
    .checks_enable(checks_enable), .clear(clear),
    .cycle_cnt(cycle_cnt), .hs_cnt(hs_cnt), .stall_cnt(stall_cnt), .idle_cnt(idle_cnt),
    .err_valid_drop(err_valid_drop), .err_data_change(err_data_change),
    .err_first_code(err_first_code), .err_first_cycle(err_first_cycle),
    .err_first_data(err_first_data)
  );

  dti_stream_monitor #(.W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
    .checks_enable(checks_enable), .clear(clear),
    .cycle_cnt(s_cycle_cnt), .hs_cnt(s_hs_cnt), .stall_cnt(s_stall_cnt), .idle_cnt(s_idle_cnt),
    .err_valid_drop(s_err_valid_drop), .err_data_change(s_err_data_change),
    .err_first_code(s_err_first_code), .err_first_cycle(s_err_first_cycle),
    .err_first_data(s_err_first_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [15:0] d);
    valid = v;
    ready = r;
    data  = d;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; ready = 1'b0; data = 16'h0000;
    clear = 1'b0; checks_enable = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; checks_enable = 1'b1;
    valid = 1'b1; ready = 1'b1; data = 16'h0005;
    cyc(); cyc();
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", cycle_cnt); end
    checks++; if (hs_cnt !== 32'd0) begin failures++; $display("FAIL reset_hs got=%0d exp=0", hs_cnt); end
    checks++; if ({stall_cnt, idle_cnt} !== 64'd0) begin failures++; $display("FAIL reset_stall_idle got=%0d/%0d exp=0/0", stall_cnt, idle_cnt); end
    checks++; if ({err_valid_drop, err_data_change, err_first_code} !== 4'b0) begin failures++; $display("FAIL reset_errs got=%b%b%b exp=0000", err_valid_drop, err_data_change, err_first_code); end
    checks++; if ({err_first_cycle, err_first_data} !== 48'd0) begin failures++; $display("FAIL reset_first got=%0d/%h exp=0/0000", err_first_cycle, err_first_data); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 16'(i));
    checks++; if (hs_cnt !== 32'd4) begin failures++; $display("FAIL b2b_hs got=%0d exp=4", hs_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", stall_cnt); end
    checks++; if (cycle_cnt !== 32'd4) begin failures++; $display("FAIL b2b_cycle got=%0d exp=4", cycle_cnt); end
    checks++; if (idle_cnt !== 32'd0) begin failures++; $display("FAIL b2b_idle got=%0d exp=0", idle_cnt); end
    checks++; if ({err_valid_drop, err_data_change} !== 2'b00) begin failures++; $display("FAIL b2b_errs got=%b%b exp=00", err_valid_drop, err_data_change); end
    drive(1'b0, 1'b0, 16'h0000);
    checks++; if (idle_cnt !== 32'd1) begin failures++; $display("FAIL b2b_idle1 got=%0d exp=1", idle_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 1'b0, 16'hA5A5);
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL stall_latency got=%0d exp=1", stall_cnt); end
    drive(1'b1, 1'b0, 16'hA5A5);
    drive(1'b1, 1'b0, 16'hA5A5);
    drive(1'b1, 1'b1, 16'hA5A5);
    checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    checks++; if (hs_cnt !== 32'd1) begin failures++; $display("FAIL stall_hs got=%0d exp=1", hs_cnt); end
    checks++; if ({err_valid_drop, err_data_change} !== 2'b00) begin failures++; $display("FAIL stall_errs got=%b%b exp=00", err_valid_drop, err_data_change); end
  endtask

  task automatic test_data_change();
    do_reset();
    drive(1'b1, 1'b0, 16'h0011);
    drive(1'b1, 1'b0, 16'h0022);
    checks++; if (err_data_change !== 1'b1) begin failures++; $display("FAIL dc_flag got=%b exp=1", err_data_change); end
    checks++; if (err_valid_drop !== 1'b0) begin failures++; $display("FAIL dc_vd_flag got=%b exp=0", err_valid_drop); end
    checks++; if (err_first_code !== 2'b10) begin failures++; $display("FAIL dc_code got=%b exp=10", err_first_code); end
    checks++; if (err_first_data !== 16'h0022) begin failures++; $display("FAIL dc_data got=%h exp=0022", err_first_data); end
    checks++; if (err_first_cycle !== 32'd1) begin failures++; $display("FAIL dc_cycle got=%0d exp=1", err_first_cycle); end
    drive(1'b0, 1'b0, 16'h0033);
    checks++; if (err_valid_drop !== 1'b1) begin failures++; $display("FAIL dc_later_vd got=%b exp=1", err_valid_drop); end
    checks++; if (err_first_code !== 2'b10) begin failures++; $display("FAIL dc_frozen_code got=%b exp=10", err_first_code); end
    checks++; if ({err_first_cycle, err_first_data} !== {32'd1, 16'h0022}) begin failures++; $display("FAIL dc_frozen got=%0d/%h exp=1/0022", err_first_cycle, err_first_data); end
  endtask

  task automatic test_disabled_clear();
    do_reset();
    checks_enable = 1'b0;
    drive(1'b1, 1'b0, 16'h0011);
    drive(1'b1, 1'b0, 16'h0022);
    checks++; if ({err_valid_drop, err_data_change} !== 2'b00) begin failures++; $display("FAIL dis_flags got=%b%b exp=00", err_valid_drop, err_data_change); end
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL dis_stall got=%0d exp=2", stall_cnt); end
    checks_enable = 1'b1;
    clear = 1'b1;
    drive(1'b0, 1'b0, 16'h0077);
    checks++; if ({err_valid_drop, err_data_change} !== 2'b10) begin failures++; $display("FAIL clr_vd_flags got=%b%b exp=10", err_valid_drop, err_data_change); end
    checks++; if (err_first_code !== 2'b01) begin failures++; $display("FAIL clr_code got=%b exp=01", err_first_code); end
    checks++; if ({err_first_cycle, err_first_data} !== {32'd0, 16'h0077}) begin failures++; $display("FAIL clr_first got=%0d/%h exp=0/0077", err_first_cycle, err_first_data); end
    checks++; if ({cycle_cnt, hs_cnt, stall_cnt, idle_cnt} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin failures++; $display("FAIL clr_counters got=%0d/%0d/%0d/%0d exp=1/0/0/1", cycle_cnt, hs_cnt, stall_cnt, idle_cnt); end
    drive(1'b0, 1'b0, 16'h0000);
    checks++; if ({err_valid_drop, err_first_code, err_first_cycle, err_first_data} !== 51'd0) begin failures++; $display("FAIL clr_plain got=%b/%b/%0d/%h exp=0/00/0/0000", err_valid_drop, err_first_code, err_first_cycle, err_first_data); end
    checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL clr_plain_cycle got=%0d exp=1", cycle_cnt); end
    clear = 1'b0;
  endtask

  task automatic test_checks_toggle();
    do_reset();
    drive(1'b1, 1'b0, 16'h0001);
    checks_enable = 1'b0;
    drive(1'b1, 1'b0, 16'h0002);
    checks++; if (err_data_change !== 1'b0) begin failures++; $display("FAIL tog_masked got=%b exp=0", err_data_change); end
    checks_enable = 1'b1;
    drive(1'b1, 1'b0, 16'h0002);
    checks++; if (err_data_change !== 1'b0) begin failures++; $display("FAIL tog_same got=%b exp=0", err_data_change); end
    drive(1'b1, 1'b0, 16'h0003);
    checks++; if ({err_data_change, err_first_code} !== 3'b110) begin failures++; $display("FAIL tog_dc got=%b/%b exp=1/10", err_data_change, err_first_code); end
    checks++; if (err_first_cycle !== 32'd3) begin failures++; $display("FAIL tog_cycle got=%0d exp=3", err_first_cycle); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 16'(i));
    checks++; if (s_hs_cnt !== 4'd15) begin failures++; $display("FAIL sat_hs got=%0d exp=15", s_hs_cnt); end
    checks++; if (s_cycle_cnt !== 4'd15) begin failures++; $display("FAIL sat_cycle got=%0d exp=15", s_cycle_cnt); end
    checks++; if (hs_cnt !== 32'd20) begin failures++; $display("FAIL sat_wide_hs got=%0d exp=20", hs_cnt); end
    drive(1'b1, 1'b0, 16'h0100);
    checks++; if ({s_hs_cnt, s_stall_cnt, s_cycle_cnt} !== {4'd15, 4'd1, 4'd15}) begin failures++; $display("FAIL sat_hold got=%0d/%0d/%0d exp=15/1/15", s_hs_cnt, s_stall_cnt, s_cycle_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 1'b0, 16'h0010);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0010);
    checks++; if ({cycle_cnt, stall_cnt, err_valid_drop, err_data_change} !== 66'd0) begin failures++; $display("FAIL mrst_zero got=%0d/%0d/%b%b exp=0/0/00", cycle_cnt, stall_cnt, err_valid_drop, err_data_change); end
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0020);
    checks++; if ({err_valid_drop, err_data_change} !== 2'b00) begin failures++; $display("FAIL mrst_noerr got=%b%b exp=00", err_valid_drop, err_data_change); end
    checks++; if ({cycle_cnt, stall_cnt} !== {32'd1, 32'd1}) begin failures++; $display("FAIL mrst_cnt got=%0d/%0d exp=1/1", cycle_cnt, stall_cnt); end
    drive(1'b1, 1'b1, 16'h0020);
    checks++; if ({hs_cnt, err_data_change} !== {32'd1, 1'b0}) begin failures++; $display("FAIL mrst_hs got=%0d/%b exp=1/0", hs_cnt, err_data_change); end
  endtask

  initial begin
    rst = 1'b1; data = '0; valid = 1'b0; ready = 1'b0;
    checks_enable = 1'b1; clear = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_data_change();
    test_disabled_clear();
    test_checks_toggle();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dti_stream_monitor.md
Name: dti_stream_monitor

Overview:
Synthesizable passive checker and statistics collector for one DTI (data/valid/ready) channel. It attaches to the same wires as the DTI verification interface and observes the monitor view only. It never drives data, valid or ready. It gives FPGA and emulation builds the same hold-valid/stable-data protocol check that simulation gets from assertions, plus handshake and stall counters that software reads back.

Parameters:
W, 16, data width in bits (equals $size(DATA_T) on the observed channel)
CNT_W, 32, width of every counter; counters saturate at 2**CNT_W-1

Ports:
clk  input  1  clock; all sampling on posedge
rst  input  1  synchronous reset, active-high
data  input  W  observed channel data
valid  input  1  observed channel valid
ready  input  1  observed channel ready
checks_enable  input  1  1 = protocol violations are recorded
clear  input  1  synchronous clear of counters and sticky errors
cycle_cnt  output  CNT_W  free-running cycle count since reset/clear
hs_cnt  output  CNT_W  handshakes (valid & ready)
stall_cnt  output  CNT_W  cycles with valid & ~ready
idle_cnt  output  CNT_W  cycles with ~valid
err_valid_drop  output  1  sticky: valid deasserted before handshake completed
err_data_change  output  1  sticky: data changed while transfer pending
err_first_code  output  2  first error type: bit0 = valid_drop, bit1 = data_change (both bits set if simultaneous)
err_first_cycle  output  CNT_W  cycle_cnt value of the cycle in which the first error was sampled
err_first_data  output  W  data sampled in the first error cycle

Behaviour:
- Reset (rst=1 at posedge): every output is 0; internal pending=0, prev_data=0. While rst=1, nothing is counted or checked.
- Sampling: at each posedge with rst=0, the block samples data, valid and ready. Every output updates one cycle after the sampled cycle (1-cycle latency).
- Pending tracking: pending <= valid & ~ready; prev_data <= data. Tracking runs regardless of checks_enable.
- Violation in a sampled cycle, evaluated only when pending=1:
  - valid=0 -> valid_drop
  - valid=1 and data != prev_data -> data_change
- A violation is recorded only if checks_enable=1 in that cycle. When pending=1 and valid=0, data is not compared.
- Sticky errors:
  - err_valid_drop and err_data_change set on a recorded violation and hold until rst or clear.
  - err_first_* load only when no error is yet recorded (both sticky bits 0).
  - After loading, err_first_* are frozen.
- Counters:
  - hs_cnt, stall_cnt and idle_cnt increment by exactly one of them per sampled cycle; these three categories are mutually exclusive.
  - cycle_cnt increments every non-reset cycle.
  - All counters saturate: no wrap-around, they hold at max.
- Clear (clear=1, rst=0):
  - Counters load the current cycle's increment (0 or 1) instead of accumulating.
  - Sticky errors and err_first_* clear, except that a violation recorded in the same cycle wins: it sets its flag and loads err_first_* with cycle_cnt=0.
  - pending and prev_data are not affected by clear.
- Mid-transfer reset: pending clears. The first post-reset cycle is never a violation, even if valid is high with changed data.
- checks_enable toggled mid-transfer: only cycles sampled with checks_enable=1 can record errors. Pending state carries across the toggle.

Test Plan:
- Reset, then 4 back-to-back handshakes (valid=ready=1, data 1,2,3,4) -> hs_cnt=4, stall_cnt=0, cycle_cnt=4, no errors.
- valid=1, data=0xA5A5, ready=0 for 3 cycles, then ready=1 -> stall_cnt=3, hs_cnt=1, no errors.
- valid=1 data=0x0011 ready=0, next cycle data=0x0022 -> err_data_change=1, err_first_code=2'b10, err_first_data=0x0022, err_first_cycle=1. A later valid drop sets err_valid_drop but leaves err_first_* unchanged.
- Same data-change stimulus with checks_enable=0 -> no flags. Then clear=1 together with a valid drop (pending=1, valid=0) -> err_valid_drop=1, err_first_cycle=0, all counters 0 or 1.
- CNT_W=4, 20 handshakes -> hs_cnt=15 (saturated), cycle_cnt=15.
- Pending transfer, rst pulsed 1 cycle, then valid=1 with new data, ready=0 -> no error; all outputs 0 in the reset cycle.
